// File: rtl/aes_pkg.sv
// aes_pkg: shared AES S-box, field arithmetic, round-count helper and FSM encodings
package aes_pkg;

    typedef enum logic [1:0] {IDLE, SUB, ADD, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_key_sched.sv
// aes_key_sched: rolling NK-word KeyExpansion window, advanced by four words per step
module aes_key_sched import aes_pkg::*; #(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [255:0] key,
    output logic [127:0] round_key
);
    logic [31:0] win   [8];
    logic [31:0] win_n [8];
    logic [31:0] nw    [4];
    logic [31:0] prev, sin, rw, sw;
    logic [7:0]  rcon;
    logic [3:0]  pos, p4;
    logic        late, rot, hit;
    // for NK=6 the i mod 6 == 0 word can land on slot 2 of a step; its input is then a chained word
    assign late = NK == 6 && pos == 4'd4;
    assign rot  = pos == 4'd0 || late;
    assign hit  = rot || (NK == 8 && pos == 4'd4);
    assign sin  = late ? win[0] ^ win[1] ^ win[NK-1] : win[NK-1];
    assign rw   = rot ? {sin[23:0], sin[31:24]} : sin;
    assign sw   = sub_word(rw) ^ {rot ? rcon : 8'h00, 24'h0};
    assign p4   = pos + 4'd4;
    always_comb begin
        prev = win[NK-1];
        for (int j = 0; j < 4; j++) begin
            nw[j] = win[j] ^ (hit && (late ? j == 2 : j == 0) ? sw : prev);
            prev  = nw[j];
        end
        win_n = win;
        for (int k = 0; k < NK - 4; k++) win_n[k] = win[k+4];
        for (int j = 0; j < 4; j++) win_n[NK-4+j] = nw[j];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win  <= '{default: '0};
            rcon <= '0;
            pos  <= '0;
        end else if (load) begin
            for (int k = 0; k < 8; k++) win[k] <= key[255-32*k -: 32];
            rcon <= 8'h01;
            pos  <= '0;
        end else if (step) begin
            win  <= win_n;
            rcon <= rot ? xtime(rcon) : rcon;
            pos  <= p4 >= 4'(NK) ? p4 - 4'(NK) : p4;
        end
    end
    assign round_key = {win[0], win[1], win[2], win[3]};
endmodule

// File: rtl/aes_enc_nk.sv
// aes_enc_nk: iterative AES encryptor for 128/192/256-bit keys, one SUB+ADD pass per round
module aes_enc_nk import aes_pkg::*; #(
    parameter int NK        = 4,
    parameter int FAST_MODE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] s_aes_key,
    input  logic [127:0] s_aes_block,
    input  logic         s_aes_valid,
    output logic         s_aes_ready,
    output logic [127:0] m_aes_block,
    output logic         m_aes_valid,
    input  logic         m_aes_ready,
    output logic [3:0]   round,
    output logic [127:0] last_round_key
);
    localparam int NR = nr_of(NK);
    state_t       state, state_n;
    logic [127:0] blk, sub_blk, sr_blk, mc_blk, rk;
    logic [3:0]   rnd;
    logic [1:0]   wcnt;
    logic         rdy, accept, last;

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    assign accept = state == IDLE && rdy && s_aes_valid;
    assign last   = rnd == 4'(NR);
    always_comb begin
        sr_blk = '0;
        mc_blk = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr_blk[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) mc_blk[127-32*c -: 32] = mix_col(sr_blk[127-32*c -: 32]);
    end
    if (FAST_MODE != 0) begin : g_fast
        for (genvar g = 0; g < 4; g++) assign sub_blk[32*g +: 32] = sub_word(blk[32*g +: 32]);
    end else begin : g_slow
        logic [31:0] sw;
        assign sw = sub_word(blk[{~wcnt, 5'd31} -: 32]);
        always_comb begin
            sub_blk = blk;
            sub_blk[{~wcnt, 5'd31} -: 32] = sw;
        end
    end
    aes_key_sched #(.NK(NK)) u_key (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (state == SUB && wcnt == 2'd0),
        .key       (s_aes_key),
        .round_key (rk)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = accept ? SUB : IDLE;
            SUB:  state_n = (FAST_MODE != 0 || wcnt == 2'd3) ? ADD : SUB;
            ADD:  state_n = last ? DONE : SUB;
            DONE: state_n = m_aes_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            blk   <= '0;
            rnd   <= '0;
            wcnt  <= '0;
            rdy   <= 1'b0;
        end else begin
            state <= state_n;
            rdy   <= state_n == IDLE;
            if (accept) begin
                blk  <= s_aes_block ^ s_aes_key[255 -: 128];
                rnd  <= 4'd1;
                wcnt <= '0;
            end else if (state == SUB) begin
                blk <= sub_blk;
                if (FAST_MODE == 0) wcnt <= wcnt + 2'd1;
            end else if (state == ADD) begin
                blk <= (last ? sr_blk : mc_blk) ^ rk;
                if (!last) rnd <= rnd + 4'd1;
            end
        end
    end
    assign s_aes_ready    = rdy;
    assign m_aes_valid    = state == DONE;
    assign m_aes_block    = blk;
    assign round          = rnd;
    assign last_round_key = rk;
endmodule

// File: tb/tb_aes_enc_nk.sv
// tb_aes_enc_nk: known-answer vectors on NK=4/6/8 and slow-mode instances, plus backpressure and reset-abort
module tb_aes_enc_nk;
    import aes_pkg::*;

    typedef struct {int g; logic [255:0] key; logic [127:0] pt; logic [127:0] ct; logic [127:0] lrk; bit chk_lrk;} vec_t;
    typedef struct {logic [127:0] ct; logic [127:0] lrk; bit chk_lrk; int lat;} exp_t;

    function automatic int nk_of(input int g);
        return g == 2 ? 6 : g == 3 ? 8 : 4;
    endfunction
    function automatic int fm_of(input int g);
        return g == 1 ? 0 : 1;
    endfunction
    function automatic int lat_of(input int g);
        return fm_of(g) != 0 ? 2 * (nk_of(g) + 6) : 5 * (nk_of(g) + 6);
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key  [4];
    logic [127:0] pt   [4];
    logic [127:0] mblk [4];
    logic [127:0] lrk  [4];
    logic [3:0]   rnd  [4];
    logic         sv [4];
    logic         sr [4];
    logic         mv [4];
    logic         mr [4];
    int           checks = 0;
    int           failures = 0;
    exp_t         sb [$];
    vec_t         vt [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes_enc_nk #(.NK(nk_of(g)), .FAST_MODE(fm_of(g))) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .s_aes_key      (key[g]),
            .s_aes_block    (pt[g]),
            .s_aes_valid    (sv[g]),
            .s_aes_ready    (sr[g]),
            .m_aes_block    (mblk[g]),
            .m_aes_valid    (mv[g]),
            .m_aes_ready    (mr[g]),
            .round          (rnd[g]),
            .last_round_key (lrk[g])
        );
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic start(input vec_t v);
        int n = 0;
        while (!sr[v.g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", sr[v.g], 1);
        key[v.g] = v.key;
        pt[v.g]  = v.pt;
        sv[v.g]  = 1'b1;
        sb.push_back('{v.ct, v.lrk, v.chk_lrk, lat_of(v.g)});
        @(negedge clk);
        sv[v.g]  = 1'b0;
        key[v.g] = '0;
        pt[v.g]  = '0;
    endtask

    task automatic wait_out(input int g, output int n);
        n = 0;
        while (!mv[g] && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 3) check("busy_not_ready", sr[g], 0);
        end
        check("out_valid", mv[g], 1);
    endtask

    task automatic collect(input int g, input int n);
        exp_t e;
        check("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("ciphertext", mblk[g], e.ct);
        check("latency", n, e.lat);
        if (e.chk_lrk) check("last_round_key", lrk[g], e.lrk);
        mr[g] = 1'b1;
        @(negedge clk);
        mr[g] = 1'b0;
        check("post_hs_valid", mv[g], 0);
        check("post_hs_ready", sr[g], 1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        start(v);
        wait_out(v.g, n);
        collect(v.g, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vt[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef_0badf00d_12345678_9abcdef0},
                  128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
        vt[1] = '{1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
        vt[2] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        vt[3] = '{1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hffffffff_ffffffff_ffffffff_ffffffff},
                  128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        vt[4] = '{2, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hfeedface_cafef00d},
                  128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h0, 1'b0};
        vt[5] = '{3, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h0, 1'b0};
        vt[6] = '{0, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1'b0};
        for (int g = 0; g < 4; g++) begin
            key[g] = '0;
            pt[g]  = '0;
            sv[g]  = 1'b0;
            mr[g]  = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int g = 0; g < 4; g++) begin
            check("reset_ctl", {mv[g], sr[g], rnd[g]}, 0);
            check("reset_block", mblk[g], 0);
            check("reset_key", lrk[g], 0);
        end
        repeat (2) @(negedge clk);
        check("ready_in_reset", sr[0], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) check("ready_after_reset", sr[g], 1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // backpressure: output held for 10 cycles while a new request waits
        start(vt[0]);
        wait_out(0, n);
        key[0] = '0;
        pt[0]  = '0;
        sv[0]  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid", mv[0], 1);
            check("bp_block", mblk[0], vt[0].ct);
            check("bp_lrk", lrk[0], vt[0].lrk);
            check("bp_ready", sr[0], 0);
        end
        collect(0, n);
        sb.push_back('{vt[6].ct, vt[6].lrk, 1'b0, lat_of(0)});
        @(negedge clk);
        sv[0] = 1'b0;
        wait_out(0, n);
        collect(0, n);

        // reset in the middle of round 5 aborts the block
        start(vt[0]);
        n = 0;
        while (rnd[0] != 4'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_round5", rnd[0], 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", mv[0], 0);
        check("abort_ready", sr[0], 0);
        check("abort_round", rnd[0], 0);
        check("abort_block", mblk[0], 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_after", sr[0], 1);
        check("abort_valid_after", mv[0], 0);
        @(negedge clk);
        run_vec(vt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_enc_nk.md
AES_ENC_NK -- requirements
Module: aes_enc_nk

Interface
REQ-001 Parameter NK, default 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256); Nr = NK+6 rounds.
REQ-002 Parameter FAST_MODE, default 1: 1 = four word SubBytes per cycle; 0 = one word SubBytes per cycle.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 s_aes_key  in  256  cipher key, left-aligned; bits [255 -: NK*32] used, rest ignored.
REQ-006 s_aes_block  in  128  plaintext block.
REQ-007 s_aes_valid  in  1  input request.
REQ-008 s_aes_ready  out  1  input accepted when valid&ready.
REQ-009 m_aes_block  out  128  ciphertext.
REQ-010 m_aes_valid  out  1  ciphertext valid.
REQ-011 m_aes_ready  in  1  downstream accepts ciphertext.
REQ-012 round  out  4  current round count, for verification.
REQ-013 last_round_key  out  128  final round key (decipher start key), valid with m_aes_valid.

Function
REQ-014 FSM states: IDLE, SUB, ADD, DONE; s_aes_ready = 1 only in IDLE, registered, never combinational on s_aes_valid.
REQ-015 IDLE & s_aes_valid: capture key, block <= s_aes_block ^ round key 0, round <= 1, go to SUB.
REQ-016 SUB, FAST_MODE=1: SubBytes on all 16 bytes in one cycle, go to ADD.
REQ-017 SUB, FAST_MODE=0: one word per cycle, MS word first; ADD entered after 4th word.
REQ-018 ADD, round < Nr: block <= MixColumns(ShiftRows(block)) ^ round key[round], round += 1, go to SUB.
REQ-019 ADD, round == Nr: block <= ShiftRows(block) ^ round key[Nr], go to DONE; MixColumns omitted.
REQ-020 Latency from acceptance edge to m_aes_valid high: 2*Nr cycles (FAST_MODE=1) or 5*Nr cycles (FAST_MODE=0), i.e. 20/24/28 or 50/60/70.
REQ-021 DONE: m_aes_valid = 1, m_aes_block and last_round_key stable until m_aes_ready; on valid&ready go to IDLE.
REQ-022 Backpressure: m_aes_ready low holds DONE indefinitely, no input accepted.
REQ-023 s_aes_valid outside IDLE is ignored; inputs are sampled only at the accepting edge.
REQ-024 Round keys equal FIPS-197 KeyExpansion for NK; one 4-word round key produced per round.
REQ-025 Key step: RotWord+SubWord+Rcon when word index i mod NK == 0; SubWord only when NK == 8 and i mod 8 == 4; at most one SubWord per 4-word step.
REQ-026 Rcon starts 0x01, GF(2^8) doubling with 0x1b reduction (0x80 -> 0x1b -> 0x36).
REQ-027 m_aes_block shows intermediate state while busy; consumers use it only with m_aes_valid.
REQ-028 Back-to-back: next block accepted 1 cycle after DONE handshake (IDLE cycle); throughput one block per latency+2 cycles.

Reset
REQ-029 rst_n low, asynchronously: FSM IDLE, block, key window, round, rcon cleared to 0; m_aes_valid = 0, s_aes_ready = 0.
REQ-030 s_aes_ready = 1 from first rising edge after rst_n deassertion.
REQ-031 Reset mid-operation (SUB/ADD/DONE) aborts the block; no partial output is ever flagged valid.

Structure
REQ-032 Package aes_pkg holds the S-box table, Rcon doubling function, Nr-from-NK function, FSM state encodings.
REQ-033 Sub-module aes_key_sched: Nk-word key window, 4-word step per round, one SubWord, outputs current round key and last round key.
REQ-034 Data path S-box instances: 4 words (FAST_MODE=1) or 1 word (FAST_MODE=0), plus 1 word in aes_key_sched.

Verification
REQ-035 NK=4, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles (FAST_MODE=1) and 50 (FAST_MODE=0).
REQ-036 NK=6, key 000102...1617, same pt -> ct dda97ca4864cdfe06eaf70a0ec0d7191 after 24 cycles.
REQ-037 NK=8, key 000102...1e1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089 after 28 cycles.
REQ-038 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c -> last_round_key d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-039 m_aes_ready held low 10 cycles in DONE, s_aes_valid high throughout -> output stable, s_aes_ready 0, no second acceptance until handshake.
REQ-040 rst_n pulsed low at round 5 -> m_aes_valid 0, s_aes_ready 1 after release, next vector from REQ-035 encrypts correctly.
